// File: rtl/aes_pkg.sv
// aes_pkg: shared constants and FSM state type for the AES-256 round-key store
package aes_pkg;
  localparam int AES256_NUM_RK = 15;
  localparam int RK_IDX_W = 4;
  localparam int RK_W = 128;
  localparam logic [RK_IDX_W-1:0] RK_LAST = RK_IDX_W'(AES256_NUM_RK - 1);
  typedef enum logic [1:0] {IDLE, LOAD, READY, STREAM} ks_state_t;
endpackage

// File: rtl/aes256_round_key_store_if.sv
// aes256_round_key_store_if: key-load, expander and round-key stream signals of the key store
interface aes256_round_key_store_if
  import aes_pkg::*;
();
  logic key_load;
  logic [2*RK_W-1:0] short_key;
  logic [RK_W-1:0] exp_subkey;
  logic exp_valid;
  logic rk_req;
  logic rk_dir;
  logic rk_ready;
  logic rk_valid;
  logic [RK_W-1:0] rk_data;
  logic [RK_IDX_W-1:0] rk_idx;
  logic rk_last;
  logic keys_ready;
  logic load_err;
  modport master (
    output key_load, short_key, exp_subkey, exp_valid, rk_req, rk_dir, rk_ready,
    input rk_valid, rk_data, rk_idx, rk_last, keys_ready, load_err
  );
  modport slave (
    input key_load, short_key, exp_subkey, exp_valid, rk_req, rk_dir, rk_ready,
    output rk_valid, rk_data, rk_idx, rk_last, keys_ready, load_err
  );
endinterface

// File: rtl/aes_rk_regfile.sv
// aes_rk_regfile: 15x128 round-key array, one sync write port (cipher-key pair or single slot), comb read
module aes_rk_regfile
  import aes_pkg::*;
(
  input logic clk,
  input logic we,
  input logic pair,
  input logic [RK_IDX_W-1:0] waddr,
  input logic [2*RK_W-1:0] key,
  input logic [RK_W-1:0] wdata,
  input logic [RK_IDX_W-1:0] raddr,
  output logic [RK_W-1:0] rdata
);
  logic [RK_W-1:0] mem [AES256_NUM_RK];
  always_ff @(posedge clk) begin
    if (we && pair) begin
      mem[0] <= key[2*RK_W-1:RK_W];
      mem[1] <= key[RK_W-1:0];
    end else if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/aes256_round_key_store.sv
// aes256_round_key_store: captures/replays the 15 AES-256 round keys; AES_KS_DEC_ORDER_EN enables descending streams
module aes256_round_key_store
  import aes_pkg::*;
(
  input logic clk,
  input logic reset,
  aes256_round_key_store_if.slave bus
);
  ks_state_t state, state_n;
  logic [RK_IDX_W-1:0] wr_cnt, wr_cnt_n, rd_addr, first, step, term, idx_n;
  logic [RK_W-1:0] rd_data, data_n;
  logic xfer, we, pair, valid_n, last_n, kr_n, err_n;
  assign xfer = bus.rk_valid & bus.rk_ready;
`ifdef AES_KS_DEC_ORDER_EN
  logic dir;
  always_ff @(posedge clk) begin
    if (!reset) dir <= 1'b0;
    else if (state == READY && bus.rk_req && !bus.key_load) dir <= bus.rk_dir;
  end
  assign first = bus.rk_dir ? RK_LAST : '0;
  assign step = dir ? bus.rk_idx - 1'b1 : bus.rk_idx + 1'b1;
  assign term = dir ? '0 : RK_LAST;
`else
  assign first = '0;
  assign step = bus.rk_idx + 1'b1;
  assign term = RK_LAST;
`endif
  assign rd_addr = state == STREAM ? step : first;
  aes_rk_regfile u_rf (
    .clk(clk), .we(we), .pair(pair), .waddr(wr_cnt), .key(bus.short_key),
    .wdata(bus.exp_subkey), .raddr(rd_addr), .rdata(rd_data)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      wr_cnt <= '0;
      bus.rk_valid <= 1'b0;
      bus.rk_data <= '0;
      bus.rk_idx <= '0;
      bus.rk_last <= 1'b0;
      bus.keys_ready <= 1'b0;
      bus.load_err <= 1'b0;
    end else begin
      state <= state_n;
      wr_cnt <= wr_cnt_n;
      bus.rk_valid <= valid_n;
      bus.rk_data <= data_n;
      bus.rk_idx <= idx_n;
      bus.rk_last <= last_n;
      bus.keys_ready <= kr_n;
      bus.load_err <= err_n;
    end
  end
  always_comb begin
    state_n = state;
    if (bus.key_load) state_n = LOAD;
    else if (state == LOAD) state_n = !bus.exp_valid ? IDLE : (wr_cnt == RK_LAST ? READY : LOAD);
    else if (state == READY && bus.rk_req) state_n = STREAM;
    else if (state == STREAM && xfer && bus.rk_last) state_n = READY;
  end
  always_comb begin
    wr_cnt_n = wr_cnt;
    valid_n = bus.rk_valid;
    data_n = bus.rk_data;
    idx_n = bus.rk_idx;
    last_n = bus.rk_last;
    kr_n = bus.keys_ready;
    err_n = 1'b0;
    we = 1'b0;
    pair = 1'b0;
    if (bus.key_load) begin
      we = 1'b1;
      pair = 1'b1;
      wr_cnt_n = RK_IDX_W'(2);
      kr_n = 1'b0;
      valid_n = 1'b0;
      last_n = 1'b0;
    end else if (state == LOAD) begin
      we = bus.exp_valid;
      err_n = !bus.exp_valid;
      wr_cnt_n = bus.exp_valid ? wr_cnt + 1'b1 : wr_cnt;
      kr_n = bus.exp_valid && wr_cnt == RK_LAST;
    end else if (state == READY && bus.rk_req) begin
      valid_n = 1'b1;
      data_n = rd_data;
      idx_n = first;
      last_n = 1'b0;
    end else if (state == STREAM && xfer) begin
      valid_n = !bus.rk_last;
      data_n = bus.rk_last ? bus.rk_data : rd_data;
      idx_n = bus.rk_last ? bus.rk_idx : step;
      last_n = !bus.rk_last && step == term;
    end
  end
endmodule

// File: tb/tb_aes256_round_key_store.sv
// tb_aes256_round_key_store: directed self-checking bench with a replayed AES-256 key schedule as expander
module tb_aes256_round_key_store;
  import aes_pkg::*;
`ifdef AES_KS_DEC_ORDER_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif
  localparam logic [255:0] KEY = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  logic [127:0] rk [15] = '{
    128'h603deb1015ca71be2b73aef0857d7781, 128'h1f352c073b6108d72d9810a30914dff4,
    128'h9ba354118e6925afa51a8b5f2067fcde, 128'ha8b09c1a93d194cdbe49846eb75d5b9a,
    128'hd59aecb85bf3c917fee94248de8ebe96, 128'hb5a9328a2678a647983122292f6c79b3,
    128'h812c81addadf48ba24360af2fab8b464, 128'h98c5bfc9bebd198e268c3ba709e04214,
    128'h68007bacb2df331696e939e46c518d80, 128'hc814e20476a9fb8a5025c02d59c58239,
    128'hde1369676ccc5a71fa2563959674ee15, 128'h5886ca5d2e2f31d77e0af1fa27cf73c3,
    128'h749c47ab18501ddae2757e4f7401905a, 128'hcafaaae3e4d59b349adf6acebd10190d,
    128'hfe4890d1e6188d0b046df344706c631e};
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  aes256_round_key_store_if bus ();
  aes256_round_key_store dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input int n);
    bus.key_load = 1'b1;
    bus.short_key = KEY;
    tick();
    bus.key_load = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.exp_valid = 1'b1;
      bus.exp_subkey = rk[i+2];
      tick();
    end
    bus.exp_valid = 1'b0;
    bus.exp_subkey = '0;
  endtask

  task automatic start_stream(input logic d);
    bus.rk_dir = d;
    bus.rk_req = 1'b1;
    tick();
    bus.rk_req = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({bus.rk_valid, bus.rk_last, bus.keys_ready, bus.load_err} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000", {bus.rk_valid, bus.rk_last, bus.keys_ready, bus.load_err});
    end
    checks++;
    if (bus.rk_data !== '0 || bus.rk_idx !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h/%0d expected 0/0", bus.rk_data, bus.rk_idx);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_load_ascending();
    bus.key_load = 1'b1;
    bus.short_key = KEY;
    tick();
    bus.key_load = 1'b0;
    for (int i = 2; i < 15; i++) begin
      checks++;
      if (bus.keys_ready !== 1'b0) begin
        errors++;
        $display("FAIL load_keys_ready_early slot=%0d: got %b expected 0", i, bus.keys_ready);
      end
      bus.exp_valid = 1'b1;
      bus.exp_subkey = rk[i];
      tick();
    end
    bus.exp_valid = 1'b0;
    checks++;
    if (bus.keys_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_keys_ready: got %b expected 1", bus.keys_ready);
    end
    bus.rk_ready = 1'b1;
    start_stream(1'b0);
    for (int k = 0; k < 15; k++) begin
      checks++;
      if (bus.rk_valid !== 1'b1 || bus.rk_idx !== 4'(k) || bus.rk_data !== rk[k] || bus.rk_last !== (k == 14)) begin
        errors++;
        $display("FAIL asc_beat k=%0d: got v=%b idx=%0d last=%b data=%h expected v=1 idx=%0d last=%b data=%h",
                 k, bus.rk_valid, bus.rk_idx, bus.rk_last, bus.rk_data, k, k == 14, rk[k]);
      end
      tick();
    end
    checks++;
    if (bus.rk_valid !== 1'b0 || bus.keys_ready !== 1'b1) begin
      errors++;
      $display("FAIL asc_end: got v=%b kr=%b expected v=0 kr=1", bus.rk_valid, bus.keys_ready);
    end
  endtask

  task automatic test_backpressure();
    bus.rk_ready = 1'b1;
    start_stream(1'b0);
    for (int i = 0; i < 3; i++) tick();
    bus.rk_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.rk_valid !== 1'b1 || bus.rk_idx !== 4'd3 || bus.rk_data !== rk[3]) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d: got v=%b idx=%0d data=%h expected v=1 idx=3 data=%h",
                 i, bus.rk_valid, bus.rk_idx, bus.rk_data, rk[3]);
      end
    end
    bus.rk_ready = 1'b1;
    tick();
    checks++;
    if (bus.rk_idx !== 4'd4 || bus.rk_data !== rk[4]) begin
      errors++;
      $display("FAIL bp_single_xfer: got idx=%0d data=%h expected idx=4 data=%h", bus.rk_idx, bus.rk_data, rk[4]);
    end
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (bus.rk_idx !== 4'd14 || bus.rk_last !== 1'b1 || bus.rk_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_last: got idx=%0d last=%b v=%b expected idx=14 last=1 v=1", bus.rk_idx, bus.rk_last, bus.rk_valid);
    end
    tick();
    checks++;
    if (bus.rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_end: got v=%b expected 0", bus.rk_valid);
    end
  endtask

  task automatic test_direction();
    bus.rk_ready = 1'b1;
    start_stream(1'b1);
    for (int k = 0; k < 15; k++) begin
      automatic int e = DEC ? 14 - k : k;
      checks++;
      if (bus.rk_valid !== 1'b1 || bus.rk_idx !== 4'(e) || bus.rk_data !== rk[e] || bus.rk_last !== (k == 14)) begin
        errors++;
        $display("FAIL dir_beat k=%0d: got v=%b idx=%0d last=%b data=%h expected v=1 idx=%0d last=%b data=%h",
                 k, bus.rk_valid, bus.rk_idx, bus.rk_last, bus.rk_data, e, k == 14, rk[e]);
      end
      tick();
    end
    checks++;
    if (bus.rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL dir_end: got v=%b expected 0", bus.rk_valid);
    end
  endtask

  task automatic test_truncated();
    load_key(6);
    checks++;
    if (bus.load_err !== 1'b0 || bus.keys_ready !== 1'b0) begin
      errors++;
      $display("FAIL trunc_pre: got err=%b kr=%b expected 0/0", bus.load_err, bus.keys_ready);
    end
    tick();
    checks++;
    if (bus.load_err !== 1'b1 || bus.keys_ready !== 1'b0) begin
      errors++;
      $display("FAIL trunc_err: got err=%b kr=%b expected 1/0", bus.load_err, bus.keys_ready);
    end
    tick();
    checks++;
    if (bus.load_err !== 1'b0) begin
      errors++;
      $display("FAIL trunc_err_pulse: got %b expected 0", bus.load_err);
    end
    start_stream(1'b0);
    tick();
    checks++;
    if (bus.rk_valid !== 1'b0 || bus.keys_ready !== 1'b0) begin
      errors++;
      $display("FAIL trunc_req_ignored: got v=%b kr=%b expected 0/0", bus.rk_valid, bus.keys_ready);
    end
  endtask

  task automatic test_abort();
    load_key(13);
    bus.rk_ready = 1'b1;
    start_stream(1'b0);
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (bus.rk_idx !== 4'd7 || bus.rk_valid !== 1'b1) begin
      errors++;
      $display("FAIL abort_at7: got idx=%0d v=%b expected idx=7 v=1", bus.rk_idx, bus.rk_valid);
    end
    bus.key_load = 1'b1;
    tick();
    bus.key_load = 1'b0;
    checks++;
    if (bus.rk_valid !== 1'b0 || bus.keys_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_drop: got v=%b kr=%b expected 0/0", bus.rk_valid, bus.keys_ready);
    end
    for (int i = 2; i < 15; i++) begin
      bus.exp_valid = 1'b1;
      bus.exp_subkey = rk[i];
      tick();
    end
    bus.exp_valid = 1'b0;
    checks++;
    if (bus.keys_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_reload: got kr=%b expected 1", bus.keys_ready);
    end
    start_stream(1'b0);
    checks++;
    if (bus.rk_valid !== 1'b1 || bus.rk_idx !== 4'd0 || bus.rk_data !== rk[0]) begin
      errors++;
      $display("FAIL abort_restart: got v=%b idx=%0d data=%h expected v=1 idx=0 data=%h",
               bus.rk_valid, bus.rk_idx, bus.rk_data, rk[0]);
    end
    for (int i = 0; i < 15; i++) tick();
  endtask

  task automatic test_reset_stream();
    load_key(13);
    bus.rk_ready = 1'b1;
    start_stream(1'b0);
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if ({bus.rk_valid, bus.rk_last, bus.keys_ready, bus.load_err} !== 4'b0 || bus.rk_data !== '0 || bus.rk_idx !== '0) begin
      errors++;
      $display("FAIL rst_mid_stream: got v=%b last=%b kr=%b err=%b idx=%0d data=%h expected all 0",
               bus.rk_valid, bus.rk_last, bus.keys_ready, bus.load_err, bus.rk_idx, bus.rk_data);
    end
    start_stream(1'b0);
    checks++;
    if (bus.rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_req_ignored: got v=%b expected 0", bus.rk_valid);
    end
    load_key(13);
    start_stream(1'b0);
    checks++;
    if (bus.rk_valid !== 1'b1 || bus.rk_idx !== 4'd0 || bus.rk_data !== rk[0]) begin
      errors++;
      $display("FAIL rst_reload_stream: got v=%b idx=%0d data=%h expected v=1 idx=0 data=%h",
               bus.rk_valid, bus.rk_idx, bus.rk_data, rk[0]);
    end
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (bus.rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_reload_end: got v=%b expected 0", bus.rk_valid);
    end
  endtask

  initial begin
    bus.key_load = 1'b0;
    bus.short_key = '0;
    bus.exp_subkey = '0;
    bus.exp_valid = 1'b0;
    bus.rk_req = 1'b0;
    bus.rk_dir = 1'b0;
    bus.rk_ready = 1'b0;
    test_reset();
    test_load_ascending();
    test_backpressure();
    test_direction();
    test_truncated();
    test_abort();
    test_reset_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes256_round_key_store.md
# aes256_round_key_store

Captures the 15 AES-256 round keys from the 256-bit cipher key and the key-expansion stream. Stores them in a register file and replays them to the round datapath over a valid/ready stream, ascending for encryption or descending for decryption. It sits directly downstream of `AESKeyexpansion_256`: it shares that block's `start` pulse and consumes its `subkey`/`valid_skey` outputs.

## Interface
- `NUM_RK`, 15: round keys stored; fixed for AES-256.
- `RK_W`, 128: round-key width.
- `clk  in  1`: single clock, rising edge.
- `reset  in  1`: synchronous, active-low; 0 at a rising edge resets.
- `key_load  in  1`: one-cycle pulse; also drives the expander `start`.
- `short_key  in  256`: cipher key, sampled on the `key_load` cycle.
- `exp_subkey  in  128`: expander `subkey`.
- `exp_valid  in  1`: expander `valid_skey`.
- `rk_req  in  1`: one-cycle pulse requesting a 15-key stream.
- `rk_dir  in  1`: 0 = ascending 0..14, 1 = descending 14..0; sampled with `rk_req`.
- `rk_ready  in  1`: consumer ready.
- `rk_valid  out  1`: stream data valid.
- `rk_data  out  128`: round key.
- `rk_idx  out  4`: index of the key on `rk_data`.
- `rk_last  out  1`: high with the final key of the stream.
- `keys_ready  out  1`: all 15 keys are held.
- `load_err  out  1`: one-cycle pulse when expander output is truncated.

## Operation
- States: IDLE, LOAD, READY, STREAM.
- **IDLE / READY, `key_load`=1:**
  - Write `short_key[255:128]` to slot 0 and `short_key[127:0]` to slot 1.
  - Set the write counter to 2, clear `keys_ready`, go to LOAD.
- **LOAD:**
  - Each cycle `exp_valid`=1, write `exp_subkey` to slot[counter] and increment the counter.
  - The write of slot 14 goes to READY and sets `keys_ready` on the next edge.
  - `exp_valid`=0 while counter < 15: go to IDLE, pulse `load_err`, leave `keys_ready` at 0.
  - `key_load` in LOAD restarts the load from slot 0.
- **READY, `rk_req`=1:** load the read index (0, or 14 if `rk_dir`=1), go to STREAM.
- **STREAM:**
  - Present slot[index]. On `rk_valid && rk_ready`, step the index by +1 or -1.
  - The transfer with `rk_last`=1 returns the block to READY.
- `rk_req` outside READY is ignored; no queuing.
- `key_load` in STREAM aborts the stream: `rk_valid` drops on the next edge and the block enters LOAD.
- `key_load` and `rk_req` in the same cycle: `key_load` wins.
- Index arithmetic is 4-bit. Terminal values are 14 (ascending) and 0 (descending); no wrap is ever produced.

## Timing
- Reset values:
  - state IDLE; `rk_valid`, `rk_last`, `keys_ready`, `load_err` = 0.
  - `rk_data`, `rk_idx` = 0.
  - Stored key contents are not cleared.
- `key_load` at edge t: the expander asserts `valid_skey` from t+1. The block is in LOAD at t+1 and captures 13 keys on edges t+1..t+13. `keys_ready`=1 after edge t+13.
- `rk_req` at edge t: `rk_valid`=1 with the first key after edge t.
- A full stream takes 15 cycles when `rk_ready` is held at 1.
- `rk_data`, `rk_idx`, `rk_last` are registered. They are held stable while `rk_valid && !rk_ready`.
- `rk_valid` never drops without a transfer, except on abort or reset.
- Reset mid-LOAD or mid-STREAM: the next edge returns the block to IDLE with all outputs at their reset values.

## Configuration
- `AES_KS_DEC_ORDER_EN` defined: `rk_dir` is honoured and descending streams are supported.
- `AES_KS_DEC_ORDER_EN` undefined:
  - `rk_dir` is ignored; every stream is ascending 0..14.
  - The decrement path is not synthesised.

## Structure
- Shared package `aes_pkg`:
  - constants `AES256_NUM_RK`=15, `RK_IDX_W`=4, `RK_W`=128.
  - state typedef `ks_state_t` {IDLE, LOAD, READY, STREAM}.
- Sub-module `aes_rk_regfile`: 15×128 register array with one synchronous write port and one combinational read port.
- The FSM, counters and output registers live in the top module.

## Test plan
All scenarios use key `603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4` with a real `AESKeyexpansion_256` attached.
- **Load then ascending stream.** `key_load`, then `rk_req` with `rk_dir`=0 and `rk_ready`=1.
  - `keys_ready` rises 13 cycles after `key_load`.
  - Stream is idx 0 = `603deb1015ca71be2b73aef0857d7781`, idx 2 = `9ba354118e6925afa51a8b5f2067fcde`, idx 14 = `fe4890d1e6188d0b046df344706c631e` with `rk_last`=1.
  - The block returns to READY.
- **Descending stream** (`AES_KS_DEC_ORDER_EN` defined), `rk_dir`=1: first transfer is idx 14 = `fe4890d1…631e`; last is idx 0 with `rk_last`=1.
- **Backpressure.** Hold `rk_ready`=0 for 5 cycles at idx 3: `rk_data` and `rk_idx` stay unchanged, and there is exactly one transfer of idx 3.
- **Truncated load.** Force `exp_valid`=0 after 6 captures: one-cycle `load_err`, state IDLE, `keys_ready`=0, `rk_req` ignored.
- **Abort.** `key_load` during STREAM at idx 7: `rk_valid`=0 next cycle, a fresh load completes, and the next stream again starts at idx 0.
- **Reset mid-STREAM.** `reset`=0 for one edge: all outputs at their reset values; `rk_req` is ignored until a new load completes.
